// File: rtl/cic_pkg.sv
// Shared types and defaults for the CIC decimator sequencer.
package cic_pkg;

   localparam int WIDTH_DEF = 24;
   localparam int DIV_DEF   = 2;
   localparam int DEC_DEF   = 64;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WARMUP = 2'd1,
      RUN    = 2'd2
   } state_t;

endpackage

// File: rtl/cic_clkgen.sv
// PDM clock divider: half-period i_div clk cycles, one-cycle sample strobe on each rising edge.
// Latency: first rising edge i_div cycles after i_run rises; no backpressure, dropping i_run clears everything.
module cic_clkgen #(
   parameter int DIV_W = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_run,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_pdm_clk,
   output logic             o_pdm_sample
);

   logic [DIV_W-1:0] r_cnt;
   logic             r_pdm_clk;
   logic             r_sample;
   logic             w_tc;

   assign w_tc = (r_cnt == i_div - DIV_W'(1));

   always_ff @(posedge i_clk) begin
      if (i_reset || !i_run) begin
         r_cnt     <= '0;
         r_pdm_clk <= 1'b0;
         r_sample  <= 1'b0;
      end else if (w_tc) begin
         r_cnt     <= '0;
         r_pdm_clk <= ~r_pdm_clk;
         // strobe coincides with the cycle pdm_clk reads high
         r_sample  <= ~r_pdm_clk;
      end else begin
         r_cnt     <= r_cnt + DIV_W'(1);
         r_sample  <= 1'b0;
      end
   end

   assign o_pdm_clk    = r_pdm_clk;
   assign o_pdm_sample = r_sample;

endmodule

// File: rtl/cic_ctrl.sv
// Sequencer for a 1-bit-in CIC decimator: PDM clock, integrator/comb strobes, warm-up discard, output stream.
// Latency: capture CIC_LAT cycles after comb_stb, out_valid one cycle later; a word arriving while out_valid && !out_ready is dropped and flags overrun.
module cic_ctrl
   import cic_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int STAGES  = 4,
   parameter int DIV_W   = 8,
   parameter int DEC_W   = 10,
   parameter int CIC_LAT = 1,
   parameter int DIV_DEF = cic_pkg::DIV_DEF,
   parameter int DEC_DEF = cic_pkg::DEC_DEF
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_cfg_we,
   input  logic [DIV_W-1:0] i_cfg_div,
   input  logic [DEC_W-1:0] i_cfg_dec,
   input  logic             i_enable,
   output logic             o_pdm_clk,
   output logic             o_pdm_sample,
   output logic             o_comb_stb,
   input  logic [WIDTH-1:0] i_cic_val,
   output logic [WIDTH-1:0] o_out_data,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic             o_overrun,
   output logic             o_busy
);

   localparam int WCNT_W = $clog2(STAGES + 1);

   state_t             r_state;
   state_t             w_next;
   logic [DIV_W-1:0]   r_div;
   logic [DEC_W-1:0]   r_dec;
   logic [DEC_W-1:0]   r_scnt;
   logic [WCNT_W-1:0]  r_wcnt;
   logic [CIC_LAT-1:0] r_pend;
   logic [WIDTH-1:0]   r_out_data;
   logic               r_out_valid;
   logic               r_overrun;

   logic w_run;
   logic w_sample;
   logic w_comb;
   logic w_cap;
   logic w_cfg_acc;
   logic w_warm_done;

   assign w_run       = (r_state != IDLE) && i_enable;
   assign w_cfg_acc   = i_cfg_we && (r_state == IDLE);
   assign w_comb      = w_sample && (r_scnt == r_dec - DEC_W'(1));
   assign w_warm_done = w_comb && (r_wcnt == WCNT_W'(STAGES - 1));
   assign w_cap       = r_pend[CIC_LAT-1] && w_run;

   cic_clkgen #(.DIV_W(DIV_W)) u_clkgen (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_run        (w_run),
      .i_div        (r_div),
      .o_pdm_clk    (o_pdm_clk),
      .o_pdm_sample (w_sample)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (i_enable) w_next = WARMUP;
         WARMUP:  if (!i_enable) w_next = IDLE;
                  else if (w_warm_done) w_next = RUN;
         RUN:     if (!i_enable) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_div       <= DIV_W'(DIV_DEF);
         r_dec       <= DEC_W'(DEC_DEF);
         r_scnt      <= '0;
         r_wcnt      <= '0;
         r_pend      <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         if (w_cfg_acc) begin
            r_div     <= (i_cfg_div == '0) ? DIV_W'(1) : i_cfg_div;
            r_dec     <= (i_cfg_dec < DEC_W'(2)) ? DEC_W'(2) : i_cfg_dec;
            r_overrun <= 1'b0;
         end

         if (!w_run)        r_scnt <= '0;
         else if (w_sample) r_scnt <= w_comb ? '0 : r_scnt + DEC_W'(1);

         if (!w_run || r_state != WARMUP) r_wcnt <= '0;
         else if (w_comb)                 r_wcnt <= r_wcnt + WCNT_W'(1);

         // only RUN strobes schedule a capture; stopping cancels anything in flight
         if (!w_run) begin
            r_pend <= '0;
         end else begin
            r_pend[0] <= w_comb && (r_state == RUN);
            for (int i = 1; i < CIC_LAT; i++) r_pend[i] <= r_pend[i-1];
         end

         if (w_cap) begin
            if (!r_out_valid || i_out_ready) begin
               r_out_data  <= i_cic_val;
               r_out_valid <= 1'b1;
            end else begin
               r_overrun   <= 1'b1;
            end
         end else if (r_out_valid && i_out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign o_pdm_sample = w_sample;
   assign o_comb_stb   = w_comb;
   assign o_out_data   = r_out_data;
   assign o_out_valid  = r_out_valid;
   assign o_overrun    = r_overrun;
   assign o_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_cic_ctrl.sv
// Directed bench for cic_ctrl: cycle-indexed expectations for strobes, capture timing, handshake and config.
module tb_cic_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_we;
   logic [7:0]  cfg_div;
   logic [9:0]  cfg_dec;
   logic        enable;
   logic        pdm_clk;
   logic        pdm_sample;
   logic        comb_stb;
   logic [23:0] cic_val;
   logic [23:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        overrun;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int k = 0;

   always #5 clk = ~clk;

   cic_ctrl dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_cfg_we     (cfg_we),
      .i_cfg_div    (cfg_div),
      .i_cfg_dec    (cfg_dec),
      .i_enable     (enable),
      .o_pdm_clk    (pdm_clk),
      .o_pdm_sample (pdm_sample),
      .o_comb_stb   (comb_stb),
      .i_cic_val    (cic_val),
      .o_out_data   (out_data),
      .o_out_valid  (out_valid),
      .i_out_ready  (out_ready),
      .o_overrun    (overrun),
      .o_busy       (busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic test_reset();
      int bad;
      reset = 1'b1; cfg_we = 1'b0; cfg_div = '0; cfg_dec = '0;
      enable = 1'b0; cic_val = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         if ({pdm_clk, pdm_sample, comb_stb, out_valid, overrun, busy} !== 6'b0 ||
             out_data !== 24'h0) bad++;
         step();
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL reset_idle: %0d cycles with non-zero outputs, required 0", bad);
      end
   endtask

   task automatic test_config_enable();
      int bclk, bsmp, bcmb, first_vld;
      cfg_div = 8'd2; cfg_dec = 10'd4; cfg_we = 1'b1;
      step();
      cfg_we = 1'b0;
      cic_val = 24'h00ABCD;
      enable = 1'b1;
      step();
      k = 0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_warmup: got %b required 1", busy);
      end
      bclk = 0; bsmp = 0; bcmb = 0; first_vld = -1;
      while (k <= 85) begin
         if (pdm_clk !== ((k / 2) % 2 == 1)) bclk++;
         if (pdm_sample !== (k % 4 == 2)) bsmp++;
         if (comb_stb !== (k % 16 == 14)) bcmb++;
         if (out_valid === 1'b1 && first_vld < 0) first_vld = k;
         step();
      end
      checks++;
      if (bclk != 0) begin
         errors++;
         $display("FAIL pdm_clk_period4: %0d wrong cycles, required 0", bclk);
      end
      checks++;
      if (bsmp != 0) begin
         errors++;
         $display("FAIL pdm_sample_every4: %0d wrong cycles, required 0", bsmp);
      end
      checks++;
      if (bcmb != 0) begin
         errors++;
         $display("FAIL comb_every16: %0d wrong cycles, required 0", bcmb);
      end
      checks++;
      if (first_vld != 80) begin
         errors++;
         $display("FAIL first_valid_cycle: got %0d required 80", first_vld);
      end
      checks++;
      if (out_data !== 24'h00ABCD) begin
         errors++;
         $display("FAIL first_data: got %h required 00abcd", out_data);
      end
   endtask

   task automatic test_back_to_back();
      cic_val = 24'h123456;
      while (k < 95) step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 24'h123456 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL back_to_back: got vld=%b data=%h ovr=%b required 1 123456 0",
                  out_valid, out_data, overrun);
      end
   endtask

   task automatic test_overrun();
      cic_val = 24'hFEDCBA;
      while (k < 111) step();
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL overrun_early: got %b required 0", overrun);
      end
      step();
      checks++;
      if (overrun !== 1'b1 || out_valid !== 1'b1 || out_data !== 24'h123456) begin
         errors++;
         $display("FAIL overrun_hold: got ovr=%b vld=%b data=%h required 1 1 123456",
                  overrun, out_valid, out_data);
      end
   endtask

   task automatic test_cfg_in_run_ignored();
      int bad;
      cfg_dec = 10'd8; cfg_div = 8'd5; cfg_we = 1'b1;
      step();
      cfg_we = 1'b0;
      bad = 0;
      while (k < 133) begin
         if (pdm_clk !== ((k / 2) % 2 == 1)) bad++;
         if (comb_stb !== (k % 16 == 14)) bad++;
         step();
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL cfg_ignored_in_run: %0d wrong cycles, required 0", bad);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || overrun !== 1'b1) begin
         errors++;
         $display("FAIL consume_clears: got vld=%b ovr=%b required 0 1", out_valid, overrun);
      end
   endtask

   task automatic test_stop_cancel();
      int bad;
      cic_val = 24'h0F0F0F;
      while (k < 143) step();
      enable = 1'b0;
      step();
      checks++;
      if (busy !== 1'b0 || pdm_clk !== 1'b0) begin
         errors++;
         $display("FAIL stop_idle: got busy=%b pdm_clk=%b required 0 0", busy, pdm_clk);
      end
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         if ({pdm_clk, pdm_sample, comb_stb, out_valid} !== 4'b0) bad++;
         step();
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL stop_cancel_quiet: %0d active cycles, required 0", bad);
      end
   endtask

   task automatic test_clamp_reenable();
      int bad;
      cfg_div = 8'd0; cfg_dec = 10'd1; cfg_we = 1'b1;
      step();
      cfg_we = 1'b0;
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL cfg_clears_overrun: got %b required 0", overrun);
      end
      cic_val = 24'h5A5A5A;
      enable = 1'b1;
      step();
      k = 0;
      bad = 0;
      while (k <= 20) begin
         if (pdm_clk !== (k % 2 == 1)) bad++;
         if (pdm_sample !== (k % 2 == 1)) bad++;
         if (comb_stb !== (k % 4 == 3)) bad++;
         if (out_valid !== 1'b0) bad++;
         step();
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL clamp_div1_dec2_warmup: %0d wrong cycles, required 0", bad);
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== 24'h5A5A5A) begin
         errors++;
         $display("FAIL rewarm_capture: got vld=%b data=%h required 1 5a5a5a", out_valid, out_data);
      end
      enable = 1'b0;
      step();
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (busy !== 1'b0 || pdm_clk !== 1'b0 || pdm_sample !== 1'b0 || comb_stb !== 1'b0) bad++;
         if (out_valid !== 1'b1 || out_data !== 24'h5A5A5A) bad++;
         step();
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL stop_retains_valid: %0d wrong cycles, required 0", bad);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_consume: got %b required 0", out_valid);
      end
   endtask

   task automatic test_reset_mid();
      int first_smp, first_cmb;
      enable = 1'b1;
      repeat (20) step();
      reset = 1'b1;
      step();
      checks++;
      if ({busy, pdm_clk, pdm_sample, comb_stb, out_valid, overrun} !== 6'b0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got %b required 000000",
                  {busy, pdm_clk, pdm_sample, comb_stb, out_valid, overrun});
      end
      reset = 1'b0;
      step();
      k = 0;
      first_smp = -1; first_cmb = -1;
      while (k < 300) begin
         if (pdm_sample === 1'b1 && first_smp < 0) first_smp = k;
         if (comb_stb === 1'b1 && first_cmb < 0) first_cmb = k;
         step();
      end
      checks++;
      if (first_smp != 2) begin
         errors++;
         $display("FAIL reset_div_default: first sample at %0d required 2", first_smp);
      end
      checks++;
      if (first_cmb != 254) begin
         errors++;
         $display("FAIL reset_dec_default: first comb at %0d required 254", first_cmb);
      end
      enable = 1'b0;
   endtask

   initial begin
      test_reset();
      test_config_enable();
      test_back_to_back();
      test_overrun();
      test_cfg_in_run_ignored();
      test_stop_cancel();
      test_clamp_reenable();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
